// File: rtl/dram_test_pkg.sv
// ----------------------------------------------------------------------------
// dram_test_pkg : shared types and pattern helpers for DRAM memory tests. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_WR_REQ    = 3'd2,
    ST_WR_WAIT   = 3'd3,
    ST_RD_REQ    = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_DONE      = 3'd6
  } memtest_state_t;

  // Fibonacci taps 32,22,2,1 expressed as bit positions 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LANE_SALT = 32'h0101_0101;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [31:0] pattern_lane(input logic [31:0] lfsr, input logic [31:0] lane);
    return lfsr ^ (lane * LANE_SALT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dram_wb_memtest_if.sv
// ----------------------------------------------------------------------------
// dram_wb_memtest_if : Wishbone user-port bundle (master = tester). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dram_wb_memtest_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 256,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
);

  logic [ADDR_WIDTH-1:0] wb_adr;
  logic [DATA_WIDTH-1:0] wb_dat_w;
  logic [SEL_WIDTH-1:0]  wb_sel;
  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic [DATA_WIDTH-1:0] wb_dat_r;
  logic                  wb_ack;
  logic                  wb_err;

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    input  wb_dat_r, wb_ack, wb_err
  );

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    output wb_dat_r, wb_ack, wb_err
  );

endinterface

`default_nettype wire

// File: rtl/dram_pattern_lfsr.sv
// ----------------------------------------------------------------------------
// dram_pattern_lfsr : 32-bit pattern LFSR with load/step control. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dram_pattern_lfsr
  import dram_test_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= 32'd1;
    end else if (load) begin
      state <= lfsr_seed_fix(seed);
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dram_wb_memtest.sv
// ----------------------------------------------------------------------------
// dram_wb_memtest : Wishbone write/read-back sweep test of the DRAM user port. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dram_wb_memtest
  import dram_test_pkg::*;
#(
  parameter int ADDR_WIDTH     = 25,
  parameter int DATA_WIDTH     = 256,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_adr,
  input  logic [ADDR_WIDTH-1:0] num_words,
  input  logic [31:0]           seed,
  input  logic                  init_done,
  input  logic                  init_error,
  dram_wb_memtest_if.master     wb,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_adr
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  memtest_state_t        state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [31:0]           seed_q;
  logic [ADDR_WIDTH-1:0] k;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [31:0]           lfsr;
  logic [DATA_WIDTH-1:0] pattern;

  logic                  lfsr_load;
  logic                  lfsr_step;
  logic                  in_wait;
  logic                  resp;
  logic                  last_word;
  logic                  miscmp;
  logic                  tmo_hit;
  logic                  err_event;
  logic [15:0]           err_count_nx;
  logic [ADDR_WIDTH-1:0] cur_adr;

  dram_pattern_lfsr u_lfsr (
    .clk   (user_clk),
    .rst   (user_rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed_q),
    .state (lfsr)
  );

  generate
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign pattern[32*j +: 32] = pattern_lane(lfsr, 32'(j));
    end
  endgenerate

  // The LFSR is held during each wait, so the read compare uses it directly.
  always_comb begin
    cur_adr      = base_q + k;
    last_word    = (k + ADDR_WIDTH'(1)) == count_q;
    in_wait      = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
    resp         = in_wait && (wb.wb_ack || wb.wb_err);
    miscmp       = (state == ST_RD_WAIT) && wb.wb_ack && !wb.wb_err && (wb.wb_dat_r != pattern);
    tmo_hit      = in_wait && !resp && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    err_event    = (in_wait && wb.wb_err) || miscmp || tmo_hit;
    err_count_nx = (err_event && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
    lfsr_load    = (state == ST_WAIT_INIT) || ((state == ST_WR_WAIT) && resp && last_word);
    lfsr_step    = resp && !lfsr_load;
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state         <= ST_IDLE;
      base_q        <= '0;
      count_q       <= '0;
      seed_q        <= '0;
      k             <= '0;
      tmo_cnt       <= '0;
      wb.wb_adr     <= '0;
      wb.wb_dat_w   <= '0;
      wb.wb_sel     <= {SEL_WIDTH{1'b1}};
      wb.wb_cyc     <= 1'b0;
      wb.wb_stb     <= 1'b0;
      wb.wb_we      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      err_count     <= '0;
      first_err_adr <= '0;
    end else begin
      err_count <= err_count_nx;
      if (err_event && err_count == 16'd0) begin
        first_err_adr <= cur_adr;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            base_q        <= base_adr;
            count_q       <= num_words;
            seed_q        <= seed;
            k             <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            err_count     <= '0;
            first_err_adr <= '0;
            state         <= ST_WAIT_INIT;
          end
        end

        ST_WAIT_INIT: begin
          if (init_error) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            fail  <= 1'b1;
            state <= ST_DONE;
          end else if (init_done) begin
            if (count_q == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_WR_REQ;
            end
          end
        end

        // Request states are entered with cyc low, giving the idle gap between beats.
        ST_WR_REQ, ST_RD_REQ: begin
          wb.wb_cyc <= 1'b1;
          wb.wb_stb <= 1'b1;
          wb.wb_we  <= (state == ST_WR_REQ);
          wb.wb_adr <= cur_adr;
          if (state == ST_WR_REQ) begin
            wb.wb_dat_w <= pattern;
          end
          tmo_cnt <= '0;
          state   <= (state == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
        end

        ST_WR_WAIT, ST_RD_WAIT: begin
          if (resp || tmo_hit) begin
            wb.wb_cyc <= 1'b0;
            wb.wb_stb <= 1'b0;
            wb.wb_we  <= 1'b0;
          end
          if (resp) begin
            if (!last_word) begin
              k     <= k + ADDR_WIDTH'(1);
              state <= (state == ST_WR_WAIT) ? ST_WR_REQ : ST_RD_REQ;
            end else if (state == ST_WR_WAIT) begin
              k     <= '0;
              state <= ST_RD_REQ;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count_nx == 16'd0);
              fail  <= (err_count_nx != 16'd0);
              state <= ST_DONE;
            end
          end else if (tmo_hit) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            fail  <= 1'b1;
            state <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dram_wb_memtest.sv
// ----------------------------------------------------------------------------
// tb_dram_wb_memtest : scoreboard bench with a Wishbone memory model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dram_wb_memtest;

  localparam int AW  = 25;
  localparam int DW  = 256;
  localparam int SW  = DW / 8;
  localparam int TMO = 64;

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_adr = '0;
  logic [AW-1:0] num_words = '0;
  logic [31:0]   seed = '0;
  logic          init_done = 1'b1;
  logic          init_error = 1'b0;
  logic          busy, done, pass, fail;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_adr;

  int checks = 0;
  int failures = 0;

  txn_t          sbq[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int n_wr = 0, n_rd = 0;
  int hang_wr = -1, err_wr = -1, err_rd = -1, flip_adr = -1;
  bit hold_rd = 1'b0;
  int cnt = 0, lat = 0, stb_cycles = 0;
  bit cur_hang = 1'b0, cur_err = 1'b0;

  always #5 clk = ~clk;

  dram_wb_memtest_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dram_wb_memtest #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .user_clk      (clk),
    .user_rst      (rst),
    .start         (start),
    .base_adr      (base_adr),
    .num_words     (num_words),
    .seed          (seed),
    .init_done     (init_done),
    .init_error    (init_error),
    .wb            (bus),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .err_count     (err_count),
    .first_err_adr (first_err_adr)
  );

  function automatic logic [31:0] tb_lfsr(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [DW-1:0] tb_pattern(input logic [31:0] s);
    logic [DW-1:0] p;
    logic [7:0]    b;
    p = '0;
    for (int j = 0; j < DW / 32; j++) begin
      b = 8'(j);
      p[32*j +: 32] = s ^ {b, b, b, b};
    end
    return p;
  endfunction

  // Memory model: checks each new request against the scoreboard, answers after 0-3 cycles.
  always @(negedge clk) begin
    txn_t e;
    bus.wb_ack = 1'b0;
    bus.wb_err = 1'b0;
    if (rst || !(bus.wb_cyc && bus.wb_stb)) begin
      cnt = 0;
    end else begin
      if (cnt == 0) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL sb_extra: unexpected request we=%b adr=%h, required none", bus.wb_we, bus.wb_adr);
        end else begin
          e = sbq.pop_front();
          if ({bus.wb_we, bus.wb_adr} !== {e.we, e.adr}) begin
            failures++;
            $display("FAIL sb_req: got we=%b adr=%h, required we=%b adr=%h", bus.wb_we, bus.wb_adr, e.we, e.adr);
          end
          if (e.we) begin
            checks++;
            if (bus.wb_dat_w !== e.dat) begin
              failures++;
              $display("FAIL sb_wdata adr=%h: got %h, required %h", bus.wb_adr, bus.wb_dat_w, e.dat);
            end
          end
        end
        checks++;
        if (bus.wb_sel !== {SW{1'b1}}) begin
          failures++;
          $display("FAIL sb_sel: got %h, required all ones", bus.wb_sel);
        end
        cur_hang = bus.wb_we ? (n_wr == hang_wr) : hold_rd;
        cur_err  = bus.wb_we ? (n_wr == err_wr) : (n_rd == err_rd);
        if (bus.wb_we) n_wr++; else n_rd++;
        lat = $urandom_range(0, 3);
      end
      cnt++;
      stb_cycles = cnt;
      if (!cur_hang && cnt > lat) begin
        bus.wb_ack = 1'b1;
        bus.wb_err = cur_err;
        if (bus.wb_we) begin
          mem[bus.wb_adr] = bus.wb_dat_w;
        end else begin
          bus.wb_dat_r = mem.exists(bus.wb_adr) ? mem[bus.wb_adr] : '0;
          if (int'(bus.wb_adr) == flip_adr || cur_err) bus.wb_dat_r[0] = ~bus.wb_dat_r[0];
        end
      end
    end
  end

  task automatic reset_model();
    sbq.delete();
    mem.delete();
    n_wr = 0; n_rd = 0;
    hang_wr = -1; err_wr = -1; err_rd = -1; flip_adr = -1;
    hold_rd = 1'b0;
  endtask

  task automatic push_expected(input logic [AW-1:0] base, input logic [31:0] sd, input int nwr, input int nrd);
    logic [31:0] s;
    txn_t t;
    s = (sd == 32'd0) ? 32'd1 : sd;
    for (int k = 0; k < nwr; k++) begin
      t.adr = base + AW'(k); t.we = 1'b1; t.dat = tb_pattern(s);
      sbq.push_back(t);
      s = tb_lfsr(s);
    end
    for (int k = 0; k < nrd; k++) begin
      t.adr = base + AW'(k); t.we = 1'b0; t.dat = '0;
      sbq.push_back(t);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic [31:0] s);
    @(negedge clk);
    base_adr = b; num_words = n; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, pass, fail} !== 4'b0000) begin
      failures++; $display("FAIL reset_status: got %b, required 0000", {busy, done, pass, fail});
    end
    checks++;
    if (err_count !== 16'd0 || first_err_adr !== '0) begin
      failures++; $display("FAIL reset_err: got cnt=%h adr=%h, required 0/0", err_count, first_err_adr);
    end
    checks++;
    if ({bus.wb_cyc, bus.wb_stb, bus.wb_we} !== 3'b000 || bus.wb_adr !== '0 || bus.wb_dat_w !== '0) begin
      failures++; $display("FAIL reset_bus: got cyc/stb/we=%b adr=%h, required 000/0", {bus.wb_cyc, bus.wb_stb, bus.wb_we}, bus.wb_adr);
    end
    checks++;
    if (bus.wb_sel !== {SW{1'b1}}) begin
      failures++; $display("FAIL reset_sel: got %h, required all ones", bus.wb_sel);
    end
  endtask

  task automatic test_clean();
    bit ok;
    reset_model();
    push_expected(25'd0, 32'hDEADBEEF, 16, 16);
    do_start(25'd0, 25'd16, 32'hDEADBEEF);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL clean_busy: got busy=%b done=%b, required 1/0", busy, done);
    end
    repeat (10) @(negedge clk);
    do_start(25'h55, 25'd3, 32'h1234);  // ignored while busy
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL clean_timeout: done never rose, required 1"); end
    checks++;
    if ({done, pass, fail, busy} !== 4'b1100) begin
      failures++; $display("FAIL clean_result: got done/pass/fail/busy=%b, required 1100", {done, pass, fail, busy});
    end
    checks++;
    if (err_count !== 16'd0 || first_err_adr !== '0) begin
      failures++; $display("FAIL clean_err: got cnt=%h adr=%h, required 0/0", err_count, first_err_adr);
    end
    checks++;
    if (sbq.size() != 0 || n_wr != 16 || n_rd != 16) begin
      failures++; $display("FAIL clean_count: got wr=%0d rd=%0d left=%0d, required 16/16/0", n_wr, n_rd, sbq.size());
    end
  endtask

  task automatic test_bitflip();
    bit ok;
    reset_model();
    flip_adr = 5;
    push_expected(25'd0, 32'h1234_5678, 16, 16);
    do_start(25'd0, 25'd16, 32'h1234_5678);
    wait_done(ok);
    checks++;
    if (!ok || {done, pass, fail} !== 3'b101) begin
      failures++; $display("FAIL flip_result: got done/pass/fail=%b, required 101", {done, pass, fail});
    end
    checks++;
    if (err_count !== 16'd1 || first_err_adr !== 25'd5) begin
      failures++; $display("FAIL flip_err: got cnt=%0d adr=%h, required 1/5", err_count, first_err_adr);
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL flip_left: got %0d, required 0", sbq.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    reset_model();
    push_expected(25'h1FFFFFE, 32'd0, 4, 4);
    do_start(25'h1FFFFFE, 25'd4, 32'd0);
    checks++;
    if (done !== 1'b0 || err_count !== 16'd0 || first_err_adr !== '0 || fail !== 1'b0) begin
      failures++; $display("FAIL wrap_clear: got done=%b fail=%b cnt=%0d adr=%h, required 0/0/0/0", done, fail, err_count, first_err_adr);
    end
    wait_done(ok);
    checks++;
    if (!ok || {done, pass, fail} !== 3'b110 || err_count !== 16'd0) begin
      failures++; $display("FAIL wrap_result: got done/pass/fail=%b cnt=%0d, required 110/0", {done, pass, fail}, err_count);
    end
    checks++;
    if (sbq.size() != 0 || n_wr != 4 || n_rd != 4) begin
      failures++; $display("FAIL wrap_count: got wr=%0d rd=%0d left=%0d, required 4/4/0", n_wr, n_rd, sbq.size());
    end
  endtask

  task automatic test_err_resp();
    bit ok;
    reset_model();
    err_wr = 1;
    err_rd = 3;
    push_expected(25'h40, 32'hCAFE_F00D, 8, 8);
    do_start(25'h40, 25'd8, 32'hCAFE_F00D);
    wait_done(ok);
    checks++;
    if (!ok || {done, pass, fail} !== 3'b101) begin
      failures++; $display("FAIL werr_result: got done/pass/fail=%b, required 101", {done, pass, fail});
    end
    checks++;
    if (err_count !== 16'd2 || first_err_adr !== 25'h41) begin
      failures++; $display("FAIL werr_err: got cnt=%0d adr=%h, required 2/41", err_count, first_err_adr);
    end
  endtask

  task automatic test_hang();
    bit ok;
    reset_model();
    hang_wr = 2;
    push_expected(25'h100, 32'h0BAD_CAFE, 3, 0);
    do_start(25'h100, 25'd8, 32'h0BAD_CAFE);
    wait_done(ok);
    checks++;
    if (!ok || {done, pass, fail} !== 3'b101 || bus.wb_cyc !== 1'b0 || bus.wb_stb !== 1'b0) begin
      failures++; $display("FAIL hang_result: got done/pass/fail=%b cyc=%b stb=%b, required 101/0/0", {done, pass, fail}, bus.wb_cyc, bus.wb_stb);
    end
    checks++;
    if (stb_cycles != TMO) begin failures++; $display("FAIL hang_cycles: got %0d, required %0d", stb_cycles, TMO); end
    checks++;
    if (err_count !== 16'd1 || first_err_adr !== 25'h102) begin
      failures++; $display("FAIL hang_err: got cnt=%0d adr=%h, required 1/102", err_count, first_err_adr);
    end
    checks++;
    if (n_rd != 0 || n_wr != 3 || sbq.size() != 0) begin
      failures++; $display("FAIL hang_count: got wr=%0d rd=%0d left=%0d, required 3/0/0", n_wr, n_rd, sbq.size());
    end
  endtask

  task automatic test_init_fail();
    bit ok;
    reset_model();
    init_error = 1'b1;
    init_done  = 1'b0;
    do_start(25'd0, 25'd8, 32'h1);
    wait_done(ok);
    checks++;
    if (!ok || {done, pass, fail, busy} !== 4'b1010) begin
      failures++; $display("FAIL init_result: got done/pass/fail/busy=%b, required 1010", {done, pass, fail, busy});
    end
    checks++;
    if (n_wr != 0 || n_rd != 0 || err_count !== 16'd0) begin
      failures++; $display("FAIL init_traffic: got wr=%0d rd=%0d cnt=%0d, required 0/0/0", n_wr, n_rd, err_count);
    end
    init_error = 1'b0;
    init_done  = 1'b1;
  endtask

  task automatic test_reset_rd_wait();
    bit ok;
    bit seen;
    reset_model();
    hold_rd = 1'b1;
    push_expected(25'd0, 32'h7, 4, 1);
    do_start(25'd0, 25'd4, 32'h7);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = bus.wb_cyc && !bus.wb_we;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rstrd_reach: read wait never seen, required 1"); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.wb_cyc, bus.wb_stb, busy} !== 3'b000) begin
      failures++; $display("FAIL rstrd_async: got cyc/stb/busy=%b, required 000", {bus.wb_cyc, bus.wb_stb, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_rd = 1'b0;
    do_start(25'h33, 25'd0, 32'h9);
    wait_done(ok);
    checks++;
    if (!ok || {done, pass, fail} !== 3'b110 || err_count !== 16'd0) begin
      failures++; $display("FAIL rstrd_zero: got done/pass/fail=%b cnt=%0d, required 110/0", {done, pass, fail}, err_count);
    end
    checks++;
    if (n_wr != 4 || n_rd != 1 || sbq.size() != 0) begin
      failures++; $display("FAIL rstrd_traffic: got wr=%0d rd=%0d left=%0d, required 4/1/0", n_wr, n_rd, sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bitflip();
    test_wrap();
    test_err_resp();
    test_hang();
    test_init_fail();
    test_reset_rd_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/dram_wb_memtest.md
Name: dram_wb_memtest

Overview:
- Wishbone master that drives the LiteDRAM user port (user_port_wishbone_0_*) directly upstream of the DRAM core. Replaces the single-word board check with a sweep test.
- Writes a seeded pseudo-random pattern over a programmable word range, then reads the range back and compares every word.
- Reports pass/fail, the error count and the first failing address to LEDs and debug logic.

Parameters:
- ADDR_WIDTH, 25, Wishbone word-address width of the user port.
- DATA_WIDTH, 256, user-port data width; must be a multiple of 32.
- SEL_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT_CYCLES, 4096, maximum cycles from stb assertion to ack/err before the test aborts.

Ports:
- user_clk  in  1  sole clock (DRAM core user clock)
- user_rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a test when idle
- base_adr  in  ADDR_WIDTH  first word address, sampled on start
- num_words  in  ADDR_WIDTH  words to test, sampled on start
- seed  in  32  LFSR seed, sampled on start
- init_done  in  1  DRAM calibration complete
- init_error  in  1  DRAM calibration failed
- wb_adr  out  ADDR_WIDTH  Wishbone address
- wb_dat_w  out  DATA_WIDTH  write data
- wb_sel  out  SEL_WIDTH  byte selects; always all ones
- wb_cyc, wb_stb, wb_we  out  1 each  Wishbone controls
- wb_dat_r  in  DATA_WIDTH  read data
- wb_ack, wb_err  in  1 each  Wishbone responses
- busy  out  1  test in progress
- done  out  1  test finished; held until the next start
- pass, fail  out  1 each  result; valid when done
- err_count  out  16  miscompares plus wb_err responses; saturates at 16'hFFFF
- first_err_adr  out  ADDR_WIDTH  address of the first error; 0 if none

Behaviour:
- Reset values: all outputs 0, except wb_sel, which is all ones.
- States:
  - IDLE -> WAIT_INIT on start.
  - WAIT_INIT:
    - init_error=1 -> DONE with fail.
    - init_done=1 -> WR_REQ.
    - num_words=0 -> DONE with pass immediately, after the init check.
  - WR_REQ -> WR_WAIT -> RD_REQ -> RD_WAIT -> DONE.
  - DONE -> WAIT_INIT on a new start.
  - start is ignored in every other state.
- Pattern generation:
  - Word k uses lfsr_k, where lfsr_0 = seed, or 32'h1 if seed=0.
  - The LFSR is 32-bit Fibonacci, taps 32,22,2,1, shifting left with feedback into bit 0, one step per word.
  - Lane j (bits 32j+31:32j) = lfsr_k XOR (j * 32'h01010101).
  - The read phase reloads the LFSR from the latched seed.
- Address rule: wb_adr = (base_adr + k) mod 2^ADDR_WIDTH; wrap-around is legal.
- Handshake, write phase:
  - WR_REQ drives cyc=stb=we=1 with adr and dat_w set, then moves to WR_WAIT.
  - Signals are held stable until ack or err. On ack or err, drop cyc/stb/we in the same edge and advance k.
  - After the last word, go to RD_REQ with k=0.
  - There is at least one idle cycle between transactions (cyc low for ≥1 cycle).
- Handshake, read phase:
  - Same as the write phase with we=0.
  - On ack, compare wb_dat_r against the expected word in that cycle.
- Error accounting:
  - A mismatch or a wb_err increments err_count.
  - first_err_adr latches on the first error only.
  - wb_err in the write phase also counts as an error.
  - If ack and err are asserted together, err wins.
- Timeout: a per-transaction counter runs while stb=1. Reaching TIMEOUT_CYCLES:
  - increments err_count;
  - deasserts cyc/stb;
  - enters DONE with fail.
- DONE: done=1, busy=0, pass=(err_count==0), fail=!pass.
- busy=1 in every state except IDLE and DONE.
- start in DONE:
  - clears done, pass, fail, err_count and first_err_adr;
  - re-latches base_adr, num_words and seed.
- Reset mid-transaction forces cyc/stb low immediately (asynchronous); no partial-transaction recovery is required.

Decomposition:
- Shared package dram_test_pkg holds:
  - the state enum (memtest_state_t);
  - LFSR_TAPS and LANE_SALT = 32'h01010101;
  - a function that builds the pattern word from lfsr_k.
- Sub-module dram_pattern_lfsr (load, step, seed -> 32-bit state) holds the LFSR and is shared with future traffic generators.

Test Plan:
- Correct memory model: seed=32'hDEADBEEF, base=0, num_words=16 -> 16 writes, then 16 reads in order; done=1, pass=1, err_count=0.
- Bit flip: model flips bit 0 of word at address 5 on read -> fail=1, err_count=1, first_err_adr=5.
- Wrap-around: base=25'h1FFFFFE, num_words=4 -> addresses 1FFFFFE, 1FFFFFF, 0, 1; pass=1.
- Hang: model never acks the 3rd write, TIMEOUT_CYCLES=64 -> cyc drops after 64 cycles, done=1, fail=1, err_count=1, no reads issued.
- Init failure: init_error=1 at start -> no Wishbone activity, done=1, fail=1.
- Reset during RD_WAIT: cyc/stb/busy go 0 asynchronously; a later start with num_words=0 gives done=1, pass=1 with no traffic.
